ex_flag_stage: RTL and testbench
================================

// Module: ex_flag_stage
// PURPOSE
//  Execute-stage back end directly downstream of the 16-bit carry-lookahead adder.
//  Captures the adder's Sum, C15 and C16 each cycle and derives the Z/N/C/V flags.
//  Optionally saturates signed overflow.
//  Registers result and flags into the EX/MEM boundary behind a valid/ready
//  handshake with a 2-entry skid buffer, so MEM-stage stalls never drop a result.
// PARAMETERS
//  WIDTH   16  datapath width; must match adder width
//  DEST_W  3   destination register index width
//  SAT_EN  0   1 = honour in_sat (signed saturation); 0 = in_sat ignored
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous squash of all held and incoming entries
//  in_valid   in   1       adder outputs and side-band are valid this cycle
//  in_ready   out  1       stage can accept an entry this cycle
//  in_sum     in   WIDTH   adder Sum
//  in_c15     in   1       carry into MSB (adder C15)
//  in_c16     in   1       carry out of MSB (adder C16)
//  in_sub     in   1       operation was A + ~B + 1 (subtract)
//  in_sat     in   1       saturate on signed overflow (only if SAT_EN=1)
//  in_dest    in   DEST_W  destination register index
//  in_wr      in   1       writeback enable
//  out_valid  out  1       out_* fields valid
//  out_ready  in   1       MEM stage accepts this cycle
//  out_result out  WIDTH   (possibly saturated) result
//  out_z/out_n/out_c/out_v  out 1 each   zero, negative, carry, signed-overflow flags
//  out_dest   out  DEST_W  passed through
//  out_wr     out  1       passed through
// BEHAVIOUR
//  Reset (rst_n=0, async): both entries invalid.
//   - All out_* = 0; out_valid = 0; in_ready = 1.
//   - Takes effect immediately, mid-transfer included. Held entries are discarded.
//  Flag derivation (combinational on input, registered with the entry):
//   - V = in_c15 ^ in_c16.
//   - C = in_sub ? ~in_c16 (borrow) : in_c16.
//   - res = in_sum, unless SAT_EN && in_sat && V:
//     then res = in_c16 ? 16'h8000 : 16'h7FFF (MSB-width generic).
//   - Z = (res == 0); N = res[WIDTH-1]. V and C reflect the unsaturated operation.
//  Storage:
//   - Main register M drives out_*.
//   - Skid register S holds one extra entry.
//   - in_ready = ~S_valid (registered, no combinational path from out_ready).
//  Accept = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
//   - Neither: hold.
//   - Accept only: if M empty or popping, load M; else load S.
//   - Pop only: M <= S if S valid (S cleared), else M invalid.
//   - Accept & pop: if S valid, M <= S and S <= input; else M <= input.
//   - Latency in_valid -> out_valid: 1 cycle when empty. Throughput: 1/cycle.
//  Ordering: strict FIFO; an entry never overtakes one accepted earlier.
//  out_* fields are stable while out_valid & ~out_ready.
//  flush (sync):
//   - Next cycle M and S are invalid and out_valid = 0.
//   - The same-cycle input is dropped. flush overrides accept and pop.
//   - The pop handshake in a flush cycle is still counted as delivered by MEM.
//  Full case (M and S valid): in_ready = 0; in_valid is ignored.
// TESTING
//  1. Add 16'h7FFF+16'h0001 (sum 8000, c15=1, c16=0, sub=0):
//     out_result=8000, V=1, N=1, C=0, Z=0 one cycle later.
//  2. Same with SAT_EN=1, in_sat=1: out_result=7FFF, V=1, N=0.
//     16'h8000+16'hFFFF (sum 7FFF, c15=0, c16=1): result 8000, V=1, C=1.
//  3. Sub 5-5 (sum 0000, c16=1, sub=1): Z=1, C=0 (no borrow), V=0.
//     Sub 3-5 (sum FFFE, c16=0): C=1, N=1.
//  4. out_ready=0, push 3 entries: first two accepted and in_ready=0 after the 2nd;
//     3rd held off. Release: outputs appear in order, one per cycle.
//  5. Two entries held, flush=1 with in_valid=1: next cycle out_valid=0, in_ready=1;
//     the flushed input never appears.
//  6. Drop rst_n mid-stream with out_valid=1: outputs go to 0 asynchronously, before the next edge.
//     After release, the first new entry appears after 1 cycle.

Source files
------------

// File: rtl/ex_flag_stage_if.sv
// EX/MEM boundary bundle: adder side-band in, flagged result out, valid/ready both ways.
interface ex_flag_stage_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEST_W = 3
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_sum;
    logic              in_c15;
    logic              in_c16;
    logic              in_sub;
    logic              in_sat;
    logic [DEST_W-1:0] in_dest;
    logic              in_wr;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_z;
    logic              out_n;
    logic              out_c;
    logic              out_v;
    logic [DEST_W-1:0] out_dest;
    logic              out_wr;

    modport master (
        output flush, in_valid, in_sum, in_c15, in_c16, in_sub, in_sat, in_dest, in_wr,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_z, out_n, out_c, out_v, out_dest, out_wr
    );

    modport slave (
        input  flush, in_valid, in_sum, in_c15, in_c16, in_sub, in_sat, in_dest, in_wr,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_z, out_n, out_c, out_v, out_dest, out_wr
    );
endinterface

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: derives Z/N/C/V from the CLA outputs, optionally saturates,
// and hands the result to MEM through a two-entry (main + skid) register pair.
module ex_flag_stage #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEST_W = 3,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_flag_stage_if.slave   bus
);
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic              z;
        logic              n;
        logic              c;
        logic              v;
        logic [DEST_W-1:0] dest;
        logic              wr;
    } entry_t;

    entry_t in_entry;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    logic   in_ready_q;
    logic   accept;
    logic   pop;

    // Flags track the raw operation; only result/Z/N see the saturated value.
    always_comb begin
        in_entry        = '0;
        in_entry.v      = bus.in_c15 ^ bus.in_c16;
        in_entry.c      = bus.in_sub ? ~bus.in_c16 : bus.in_c16;
        in_entry.result = bus.in_sum;
        if (SAT_EN && bus.in_sat && in_entry.v) begin
            in_entry.result = bus.in_c16 ? SAT_MIN : SAT_MAX;
        end
        in_entry.z      = (in_entry.result == '0);
        in_entry.n      = in_entry.result[WIDTH-1];
        in_entry.dest   = bus.in_dest;
        in_entry.wr     = bus.in_wr;
    end

    assign accept = bus.in_valid & in_ready_q & ~bus.flush;
    assign pop    = m_valid_q & bus.out_ready;

    // Main/skid next state; the skid entry always drains into main first to keep FIFO order.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (bus.flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            unique case ({accept, pop})
                2'b10: begin
                    if (!m_valid_q) begin
                        m_valid_d = 1'b1;
                        m_d       = in_entry;
                    end else begin
                        s_valid_d = 1'b1;
                        s_d       = in_entry;
                    end
                end
                2'b01: begin
                    if (s_valid_q) begin
                        m_d       = s_q;
                        s_valid_d = 1'b0;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (s_valid_q) begin
                        m_d = s_q;
                        s_d = in_entry;
                    end else begin
                        m_d = in_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= ~s_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = m_valid_q;
    assign bus.out_result = m_q.result;
    assign bus.out_z      = m_q.z;
    assign bus.out_n      = m_q.n;
    assign bus.out_c      = m_q.c;
    assign bus.out_v      = m_q.v;
    assign bus.out_dest   = m_q.dest;
    assign bus.out_wr     = m_q.wr;
endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: integer-arithmetic reference model, randomized
// traffic with stalls and flushes, plus directed flag, skid, flush and reset scenarios.
module tb_ex_flag_stage;
    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic [2:0]  dest;
        logic        wr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sbq[$];
    logic stalled_prev;
    logic [23:0] prev_fields;

    ex_flag_stage_if #(.WIDTH(16), .DEST_W(3)) bus ();

    ex_flag_stage #(.WIDTH(16), .DEST_W(3), .SAT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Upstream CLA behaviour: A + B, or A + ~B + 1 for subtract.
    task automatic adder(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] sum, output logic c15, output logic c16);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] low;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 17'(sub);
        low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + 16'(sub);
        sum  = full[15:0];
        c16  = full[16];
        c15  = low[15];
    endtask

    // Reference from true signed/unsigned results rather than carry bits.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                   input logic sat, input logic [2:0] dest, input logic wr);
        exp_t e;
        int sa, sb, tr;
        int unsigned ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        tr = sub ? sa - sb : sa + sb;
        e.v = (tr > 32767) || (tr < -32768);
        e.c = sub ? (ua < ub) : ((ua + ub) > 32'd65535);
        if (sat && e.v) e.res = (tr > 0) ? 16'h7FFF : 16'h8000;
        else            e.res = 16'(tr);
        e.z    = (e.res == 16'h0000);
        e.n    = e.res[15];
        e.dest = dest;
        e.wr   = wr;
        return e;
    endfunction

    function automatic logic [23:0] out_fields();
        return {bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v, bus.out_dest, bus.out_wr};
    endfunction

    // Monitor: pops on each handshake, checks stall stability, mirrors flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (bus.out_valid && stalled_prev)
                chk("stable_while_stalled", 32'(out_fields()), 32'(prev_fields));
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 32'(out_fields()), 32'hDEAD);
                end else begin
                    exp_t e;
                    logic [23:0] ev;
                    e  = sbq.pop_front();
                    ev = e;
                    chk("scoreboard", 32'(out_fields()), 32'(ev));
                end
            end
            stalled_prev = bus.out_valid & ~bus.out_ready;
            prev_fields  = out_fields();
            if (bus.flush) sbq.delete();
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat, input logic rdy, input logic fl,
                        output logic acc);
        logic [15:0] sum;
        logic c15, c16;
        logic [2:0] dest;
        logic wr;
        exp_t e;
        chk("in_ready_vs_occupancy", 32'(bus.in_ready), 32'(sbq.size() < 2));
        chk("out_valid_vs_occupancy", 32'(bus.out_valid), 32'(sbq.size() > 0));
        dest = 3'($urandom_range(7, 0));
        wr   = 1'($urandom_range(1, 0));
        adder(a, b, sub, sum, c15, c16);
        e = model(a, b, sub, sat, dest, wr);
        bus.in_valid  = v;
        bus.in_sum    = sum;
        bus.in_c15    = c15;
        bus.in_c16    = c16;
        bus.in_sub    = sub;
        bus.in_sat    = sat;
        bus.in_dest   = dest;
        bus.in_wr     = wr;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(negedge clk);
        acc = v & bus.in_ready & ~fl;
        if (acc) sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [5];
        edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFF;
        edges[3] = 16'h0000; edges[4] = 16'h0001;
        if ($urandom_range(3, 0) == 0) return edges[$urandom_range(4, 0)];
        return 16'($urandom());
    endfunction

    initial begin
        logic acc;
        bit   got;
        total = 0;
        bad   = 0;
        stalled_prev = 1'b0;
        prev_fields  = '0;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_c15 = 1'b0;
        bus.in_c16 = 1'b0; bus.in_sub = 1'b0; bus.in_sat = 1'b0; bus.in_dest = '0;
        bus.in_wr = 1'b0; bus.out_ready = 1'b0;
        #12;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_fields", 32'(out_fields()), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Add overflow without saturation, then saturated overflow both directions.
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk("add_ovf_latency", 32'(bus.out_valid), 32'd1);
        chk("add_ovf_result", 32'(bus.out_result), 32'h8000);
        chk("add_ovf_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'b0101);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        chk("sat_pos_result", 32'(bus.out_result), 32'h7FFF);
        chk("sat_pos_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'b0001);
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        chk("sat_neg_result", 32'(bus.out_result), 32'h8000);
        chk("sat_neg_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'b0111);
        // Subtract: equal operands (no borrow) and borrow case.
        step(1'b1, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("sub_eq_result", 32'(bus.out_result), 32'h0000);
        chk("sub_eq_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'b1000);
        step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("sub_borrow_result", 32'(bus.out_result), 32'hFFFE);
        chk("sub_borrow_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'b0110);
        idle(2);

        // Skid: two accepted under stall, third held until release.
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, pick(), pick(), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        chk("skid_full_in_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        chk("third_held", 32'(acc), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, acc);
            got = acc;
        end
        chk("third_accepted_after_release", 32'(got), 32'd1);
        chk("release_back_to_back", 32'(bus.out_valid), 32'd1);
        idle(3);

        // Flush with both entries held and a live input.
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        idle(3);

        // Async reset mid-stream.
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_fields", 32'(out_fields()), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sbq.delete();
        bus.in_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        chk("post_reset_latency", 32'(bus.out_valid), 32'd1);
        chk("post_reset_result", 32'(bus.out_result), 32'h0123);
        idle(2);

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(9, 0) < 7), pick(), pick(), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(9, 0) < 6),
                 1'($urandom_range(39, 0) == 0), acc);
        end
        idle(4);
        chk("drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
